// File: rtl/teatris_pecas_pkg.sv
// Shared constants for the Teatris piece generator: default sizes, the
// 7-segment style pattern table and the command decode type.
package teatris_pecas_pkg;

  localparam int N_PECAS_PADRAO = 4;
  localparam int N_ROT_PADRAO   = 4;
  localparam int LARGURA_PADRAO = 16;
  localparam int TAB_TAM        = 16;

  localparam logic [LARGURA_PADRAO-1:0] BRANCO = '1;

  typedef enum logic [2:0] {
    CMD_NENHUM,
    CMD_CARREGAR,
    CMD_REJEITAR,
    CMD_GIRAR,
    CMD_GIRAR_ANTI
  } comando_t;

  // Table is laid out piece-major: entry = peca*N_ROT + rotacao.
  function automatic logic [LARGURA_PADRAO-1:0] padrao_tabela(input int idx);
    logic [LARGURA_PADRAO-1:0] valor;
    case (idx)
      0:       valor = 16'hE7F7;
      1:       valor = 16'hE7E7;
      2:       valor = 16'hF7F7;
      3:       valor = 16'hE7FF;
      4:       valor = 16'hE7EF;
      5:       valor = 16'hEFE7;
      6:       valor = 16'hEFF7;
      7:       valor = 16'hF7EF;
      8:       valor = 16'hE7F7;
      9:       valor = 16'hEFE7;
      10:      valor = 16'hEFF7;
      11:      valor = 16'hF7E7;
      12:      valor = 16'hFFE7;
      13:      valor = 16'hE7E7;
      14:      valor = 16'hEFEF;
      15:      valor = 16'hF7EF;
      default: valor = BRANCO;
    endcase
    return valor;
  endfunction

endpackage

// File: rtl/teatris_tabela_pecas.sv
// Registered pattern lookup: one clock after an index is presented the
// matching pattern appears; out-of-range indices show a blank display.
module teatris_tabela_pecas
  import teatris_pecas_pkg::*;
#(
  parameter int LARGURA    = LARGURA_PADRAO,
  parameter int N_ENTRADAS = TAB_TAM,
  parameter int IW         = 5
) (
  input  logic               clock,
  input  logic [IW-1:0]      index,
  output logic [LARGURA-1:0] padrao
);

  localparam int LW = (LARGURA < LARGURA_PADRAO) ? LARGURA : LARGURA_PADRAO;

  logic [LARGURA_PADRAO-1:0] entrada;
  logic [LARGURA-1:0]        proximo;

  // Bits wider than the stored table stay at 1 (segment off).
  always_comb begin
    entrada = padrao_tabela(int'(index));
    proximo = '1;
    if (int'(index) < N_ENTRADAS && int'(index) < TAB_TAM) begin
      for (int b = 0; b < LW; b++) begin
        proximo[b] = entrada[b];
      end
    end
  end

  always_ff @(posedge clock) begin
    padrao <= proximo;
  end

endmodule

// File: rtl/teatris_gerador_pecas.sv
// Piece generator: decodes load/rotate commands into piece and rotation
// registers and drives the registered display pattern two edges later.
module teatris_gerador_pecas
  import teatris_pecas_pkg::*;
#(
  parameter int N_PECAS  = N_PECAS_PADRAO,
  parameter int N_ROT    = N_ROT_PADRAO,
  parameter int LARGURA  = LARGURA_PADRAO,
  localparam int LP      = $clog2(N_PECAS),
  localparam int LR      = $clog2(N_ROT)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               carregar,
  input  logic [LP-1:0]      peca_in,
  input  logic               girar,
  input  logic               girar_anti,
  output logic [LARGURA-1:0] padrao,
  output logic               valido,
  output logic [LP-1:0]      peca_atual,
  output logic [LR-1:0]      rotacao_atual,
  output logic               erro
);

  // One spare index bit guarantees the all-ones index lies past every entry.
  localparam int IW = LP + LR + 1;

  comando_t        comando;
  logic [LR-1:0]   rot_mais;
  logic [LR-1:0]   rot_menos;
  logic            aceito;
  logic            mostrar;
  logic [IW-1:0]   indice;

  always_comb begin
    comando = CMD_NENHUM;
    if (carregar) begin
      comando = (int'(peca_in) < N_PECAS) ? CMD_CARREGAR : CMD_REJEITAR;
    end else if (girar && !girar_anti) begin
      comando = CMD_GIRAR;
    end else if (girar_anti && !girar) begin
      comando = CMD_GIRAR_ANTI;
    end
  end

  always_comb begin
    rot_mais  = (rotacao_atual == LR'(N_ROT - 1)) ? '0 : rotacao_atual + 1'b1;
    rot_menos = (rotacao_atual == '0) ? LR'(N_ROT - 1) : rotacao_atual - 1'b1;
  end

  // Until the first accepted command after reset the display stays blank.
  always_ff @(posedge clock) begin
    if (reset) begin
      peca_atual    <= '0;
      rotacao_atual <= '0;
      mostrar       <= 1'b0;
      aceito        <= 1'b0;
      erro          <= 1'b0;
    end else begin
      erro   <= (comando == CMD_REJEITAR);
      aceito <= 1'b0;
      case (comando)
        CMD_CARREGAR: begin
          peca_atual    <= peca_in;
          rotacao_atual <= '0;
          mostrar       <= 1'b1;
          aceito        <= 1'b1;
        end
        CMD_GIRAR: begin
          rotacao_atual <= rot_mais;
          mostrar       <= 1'b1;
          aceito        <= 1'b1;
        end
        CMD_GIRAR_ANTI: begin
          rotacao_atual <= rot_menos;
          mostrar       <= 1'b1;
          aceito        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valido <= 1'b0;
    end else begin
      valido <= aceito;
    end
  end

  // Reset steers the lookup to the blank index so an in-flight update is dropped.
  always_comb begin
    if (reset || !mostrar) begin
      indice = '1;
    end else begin
      indice = IW'(peca_atual) * IW'(N_ROT) + IW'(rotacao_atual);
    end
  end

  teatris_tabela_pecas #(
    .LARGURA    (LARGURA),
    .N_ENTRADAS (N_PECAS * N_ROT),
    .IW         (IW)
  ) u_tabela (
    .clock  (clock),
    .index  (indice),
    .padrao (padrao)
  );

endmodule

// File: doc/teatris_gerador_pecas.md
TEATRIS_GERADOR_PECAS -- requirements
Module: teatris_gerador_pecas

Interface
REQ-001 SHALL have parameter N_PECAS, default 4, number of piece types (>= 2).
REQ-002 SHALL have parameter N_ROT, default 4, rotations per piece (>= 2).
REQ-003 SHALL have parameter LARGURA, default 16, pattern width in bits.
REQ-004 SHALL derive localparams LP = clog2(N_PECAS) and LR = clog2(N_ROT).
REQ-005 SHALL have `clock` as an input, 1 bit: the single system clock, rising edge.
REQ-006 SHALL have `reset` as an input, 1 bit: synchronous, active-high.
REQ-007 SHALL have `carregar` as an input, 1 bit: load a new piece from peca_in.
REQ-008 SHALL have `peca_in` as an input, LP bits: piece index to load.
REQ-009 SHALL have `girar` as an input, 1 bit: rotate clockwise (rotation +1).
REQ-010 SHALL have `girar_anti` as an input, 1 bit: rotate counter-clockwise (rotation -1).
REQ-011 SHALL have `padrao` as an output, LARGURA bits: registered display pattern (1 = segment off).
REQ-012 SHALL have `valido` as an output, 1 bit: one-cycle pulse marking a new padrao.
REQ-013 SHALL have `peca_atual` as an output, LP bits: current piece register.
REQ-014 SHALL have `rotacao_atual` as an output, LR bits: current rotation register.
REQ-015 SHALL have `erro` as an output, 1 bit: one-cycle pulse on a rejected load.

Function
REQ-016 SHALL update state registers (peca_atual, rotacao_atual) on the edge at which a command is sampled (edge E1), and register padrao and valido from the updated state on the following edge (E2); latency is 2 edges.
REQ-017 SHALL accept one command per cycle (throughput 1) and place no back-pressure on commands.
REQ-018 SHALL, on carregar with peca_in < N_PECAS, load peca_atual = peca_in and rotacao_atual = 0.
REQ-019 SHALL, on carregar with peca_in >= N_PECAS, leave state unchanged, pulse erro at E1, and not pulse valido for that command.
REQ-020 SHALL give carregar priority over girar and girar_anti when they are asserted in the same cycle; the rotate inputs are then ignored.
REQ-021 SHALL, on girar alone, set rotacao_atual = (rotacao_atual + 1) mod N_ROT, so that N_ROT-1 wraps to 0.
REQ-022 SHALL, on girar_anti alone, set rotacao_atual = (rotacao_atual - 1) mod N_ROT, so that 0 wraps to N_ROT-1.
REQ-023 SHALL treat girar and girar_anti asserted together without carregar as a no-op: no state change, no valido.
REQ-024 SHALL pulse valido at E2 for every accepted command; with no command, valido = 0 and padrao holds its value.
REQ-025 SHALL look up the pattern at table index peca_atual*N_ROT + rotacao_atual; an index beyond the table yields all ones (blank).
REQ-026 SHALL, with default parameters, use this table (index: value): 0:E7F7 1:E7E7 2:F7F7 3:E7FF 4:E7EF 5:EFE7 6:EFF7 7:F7EF 8:E7F7 9:EFE7 10:EFF7 11:F7E7 12:FFE7 13:E7E7 14:EFEF 15:F7EF (hex).
REQ-027 SHALL allow rotation from the reset state (piece 0, rotation 0) without a prior load.

Reset
REQ-028 SHALL, while reset = 1, force padrao to all ones, valido = 0, erro = 0, peca_atual = 0 and rotacao_atual = 0.
REQ-029 SHALL let reset override all commands in the same cycle.
REQ-030 SHALL let reset cancel any in-flight E2 update: no valido follows the reset.
REQ-031 SHALL ignore commands until the first edge at which reset = 0.

Structure
REQ-032 SHALL place the pattern table constant, the default N_PECAS, N_ROT and LARGURA, and the blank constant (all ones) in shared package teatris_pecas_pkg.
REQ-033 SHALL implement the synchronous table lookup as one sub-module, teatris_tabela_pecas (inputs clock and index; registered pattern output).
REQ-034 SHALL keep command decode, state registers and the valido/erro pipeline in the top module.

Verification
REQ-035 SHALL cover reset held 3 cycles -> padrao = FFFF, valido = 0, peca_atual = 0, rotacao_atual = 0.
REQ-036 SHALL cover carregar with peca_in = 0 -> 2 edges later padrao = E7F7 with valido high for exactly 1 cycle.
REQ-037 SHALL cover girar for 4 consecutive cycles from piece 0, rotation 0 -> padrao = E7E7, F7F7, E7FF, E7F7 on consecutive cycles, ending at rotacao_atual = 0.
REQ-038 SHALL cover carregar peca_in = 3 followed by girar_anti -> padrao = FFE7, then F7EF with rotacao_atual = 3.
REQ-039 SHALL cover carregar peca_in = 1 with girar in the same cycle -> piece 1, rotation 0, padrao = E7EF; then girar and girar_anti together -> no valido, padrao unchanged.
REQ-040 SHALL cover an N_PECAS = 3 build: carregar peca_in = 3 -> erro pulse, state unchanged, no valido; and reset asserted the cycle after a girar -> no valido, padrao = FFFF.
